apb_master: RTL and testbench

- APB requester; drives the same APB bus that the team's APB slave/register-file subsystem responds on.
- Converts a simple valid/ready command stream from a local controller or bench into APB transfers with SETUP and ACCESS phases.
- Decodes one-hot PSELx across NO_SLAVES targets.
- Returns read data and status on a valid/ready response channel, with a PREADY timeout watchdog.

---
 rtl/apb_master_if.sv | 46 ++++
 rtl/apb_master.sv | 169 ++++++++++++++++
 tb/tb_apb_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command/response streams and APB bus signals of the APB requester.
// The master modport is the requester's view; the slave modport is the opposite side.
interface apb_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NO_SLAVES  = 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  logic [NO_SLAVES-1:0]  PSELx;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output PSELx, PENABLE, PADDR, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  PSELx, PENABLE, PADDR, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: one outstanding transfer, one-hot slave decode from the top
// address bits, registered outputs, and a PREADY watchdog.
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NO_SLAVES  = 1,
  parameter int TIMEOUT    = 16
) (
  input logic         PCLK,
  input logic         PRESET,
  apb_master_if.master bus
);

  localparam int IDX_W = $clog2(NO_SLAVES);
  localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [NO_SLAVES-1:0]  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  logic [IW-1:0]         cmd_idx;
  logic                  idx_ok;
  logic [NO_SLAVES-1:0]  sel_dec;

  // A single target has no index bits: every address lands on slave 0.
  generate
    if (IDX_W > 0) begin : g_idx
      assign cmd_idx = bus.cmd_addr[ADDR_WIDTH-1 -: IW];
    end else begin : g_noidx
      assign cmd_idx = '0;
    end
  endgenerate

  assign idx_ok = (32'(cmd_idx) < NO_SLAVES);

  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < NO_SLAVES; i++) begin
      if (32'(cmd_idx) == i) sel_dec[i] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
    end
  end

  // Next values are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (idx_ok) begin
            state_d  = SETUP;
            psel_d   = sel_dec;
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_wdata;
          end else begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // Completion wins over a watchdog expiring in the same cycle.
        if (bus.PREADY) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d       = RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 3;
  localparam int TO = 4;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 0;

  logic PCLK;
  logic PRESET;

  apb_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NO_SLAVES(NS)) bus ();

  apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NO_SLAVES(NS), .TIMEOUT(TO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [AW-1:0] a);
    if (IDX_W == 0) return 0;
    return 32'(a >> (AW - IDX_W));
  endfunction

  // Reference model: one transaction in flight, described by whether it is on
  // the bus, how many ACCESS cycles have waited, and the pending response.
  bit               model_ok = 0;
  bit               m_busy, m_onbus, m_access, m_rsp;
  int unsigned      m_waits, m_idx;
  logic [AW-1:0]    m_addr;
  bit               m_write;
  logic [DW-1:0]    m_wdata, m_rdata;
  bit               m_err, m_to;

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_busy = 0; m_onbus = 0; m_access = 0; m_rsp = 0; m_waits = 0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy  = 1;
        m_addr  = bus.cmd_addr;
        m_write = bus.cmd_write;
        m_wdata = bus.cmd_wdata;
        m_idx   = idx_of(bus.cmd_addr);
        if (m_idx >= NS) begin
          m_rsp = 1; m_err = 1; m_to = 0; m_rdata = '0;
        end else begin
          m_onbus = 1; m_access = 0;
        end
      end
    end else if (m_onbus && !m_access) begin
      m_access = 1; m_waits = 0;
    end else if (m_onbus) begin
      if (bus.PREADY) begin
        m_onbus = 0; m_access = 0; m_rsp = 1;
        m_err = bus.PSLVERR; m_to = 0;
        m_rdata = m_write ? '0 : bus.PRDATA;
      end else if (TO != 0 && m_waits + 1 == TO) begin
        m_onbus = 0; m_access = 0; m_rsp = 1;
        m_err = 1; m_to = 1; m_rdata = '0;
      end else begin
        m_waits++;
      end
    end else if (m_rsp && bus.rsp_ready) begin
      m_rsp = 0; m_busy = 0;
    end
    model_ok = 1;
  end

  always @(negedge PCLK) begin
    logic [NS-1:0] exp_sel;
    if (model_ok) begin
      exp_sel = m_onbus ? (NS'(1) << m_idx) : '0;
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy));
      chk("PSELx", 64'(bus.PSELx), 64'(exp_sel));
      chk("PENABLE", 64'(bus.PENABLE), 64'(m_onbus && m_access));
      chk("penable_without_psel", 64'(bus.PENABLE && (bus.PSELx == '0)), 64'(0));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp));
      if (m_onbus) begin
        chk("PADDR", 64'(bus.PADDR), 64'(m_addr));
        chk("PWRITE", 64'(bus.PWRITE), 64'(m_write));
        chk("PWDATA", 64'(bus.PWDATA), 64'(m_wdata));
      end
      if (m_rsp) begin
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
        chk("rsp_slverr", 64'(bus.rsp_slverr), 64'(m_err));
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_to));
      end
    end
  end

  // Called at a falling edge; returns at the first falling edge after the accept edge.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 50) chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
  endtask

  // Cycles from accept edge until rsp_valid is seen; 'start' is the cycles already elapsed.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge PCLK);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc;
    PRESET = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1; bus.PREADY = 1; bus.PRDATA = '0; bus.PSLVERR = 0;
    repeat (3) @(negedge PCLK);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("reset_psel", 64'(bus.PSELx), 64'(0));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_paddr", 64'(bus.PADDR), 64'(0));
    PRESET = 1'b0;
    @(negedge PCLK);

    // Write, zero wait states
    issue(1, 32'h10, 32'hDEADBEEF);
    chk("wr_setup_psel", 64'(bus.PSELx), 64'h1);
    chk("wr_setup_penable", 64'(bus.PENABLE), 64'h0);
    @(negedge PCLK);
    chk("wr_access_penable", 64'(bus.PENABLE), 64'h1);
    chk("wr_access_pwdata", 64'(bus.PWDATA), 64'hDEADBEEF);
    wait_rsp(2, lat);
    chk("wr_latency", 64'(lat), 64'd3);
    chk("wr_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("wr_slverr", 64'(bus.rsp_slverr), 64'h0);
    @(negedge PCLK);

    // Read, three wait states
    bus.PREADY = 0; bus.PRDATA = 32'h12345678;
    issue(0, 32'h20, 32'h0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge PCLK);
      chk("rd_wait_penable", 64'(bus.PENABLE), 64'h1);
      chk("rd_wait_paddr", 64'(bus.PADDR), 64'h20);
    end
    bus.PREADY = 1;
    wait_rsp(5, lat);
    chk("rd_latency", 64'(lat), 64'd6);
    chk("rd_rdata", 64'(bus.rsp_rdata), 64'h12345678);
    @(negedge PCLK);

    // Slave error with response backpressure
    bus.rsp_ready = 0; bus.PSLVERR = 1;
    issue(0, 32'h30, 32'h0);
    wait_rsp(1, lat);
    chk("err_latency", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      chk("err_hold_valid", 64'(bus.rsp_valid), 64'h1);
      chk("err_hold_slverr", 64'(bus.rsp_slverr), 64'h1);
      chk("err_hold_cmd_ready", 64'(bus.cmd_ready), 64'h0);
      @(negedge PCLK);
    end
    bus.rsp_ready = 1; bus.PSLVERR = 0;
    @(negedge PCLK);
    chk("err_after_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    chk("err_after_rsp_valid", 64'(bus.rsp_valid), 64'h0);

    // Watchdog: PREADY never rises
    bus.PREADY = 0;
    issue(1, 32'h40, 32'h55);
    acc = 0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      if (bus.PENABLE === 1'b1) acc++;
      @(negedge PCLK);
      lat++;
    end
    chk("to_access_cycles", 64'(acc), 64'd4);
    chk("to_latency", 64'(lat), 64'd6);
    chk("to_psel", 64'(bus.PSELx), 64'h0);
    chk("to_slverr", 64'(bus.rsp_slverr), 64'h1);
    chk("to_flag", 64'(bus.rsp_timeout), 64'h1);
    chk("to_rdata", 64'(bus.rsp_rdata), 64'h0);
    bus.PREADY = 1;
    @(negedge PCLK);

    // Decode across three slaves; index 3 is out of range
    issue(1, 32'h4000_0000, 32'h1);
    chk("dec_idx1", 64'(bus.PSELx), 64'b010);
    wait_rsp(1, lat);
    @(negedge PCLK);
    issue(0, 32'h8000_0000, 32'h0);
    chk("dec_idx2", 64'(bus.PSELx), 64'b100);
    wait_rsp(1, lat);
    @(negedge PCLK);
    issue(1, 32'hC000_0000, 32'h2);
    chk("dec_bad_valid", 64'(bus.rsp_valid), 64'h1);
    chk("dec_bad_psel", 64'(bus.PSELx), 64'h0);
    chk("dec_bad_slverr", 64'(bus.rsp_slverr), 64'h1);
    chk("dec_bad_timeout", 64'(bus.rsp_timeout), 64'h0);
    @(negedge PCLK);

    // Reset during an ACCESS wait state
    bus.PREADY = 0;
    issue(0, 32'h50, 32'h0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1;
    @(negedge PCLK);
    chk("rst_psel", 64'(bus.PSELx), 64'h0);
    chk("rst_penable", 64'(bus.PENABLE), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    PRESET = 0; bus.PREADY = 1;
    issue(1, 32'h60, 32'hA5A5A5A5);
    wait_rsp(1, lat);
    chk("rst_next_latency", 64'(lat), 64'd3);
    chk("rst_next_slverr", 64'(bus.rsp_slverr), 64'h0);

    // Random traffic against the model
    repeat (4000) begin
      @(negedge PCLK);
      PRESET        = ($urandom_range(0, 149) == 0);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.PREADY    = ($urandom_range(0, 9) < 4);
      bus.PRDATA    = $urandom;
      bus.PSLVERR   = ($urandom_range(0, 3) == 0);
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge PCLK);
    PRESET = 0;
    @(negedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
